// File: rtl/mem_stage_cache.sv
// Memory stage: sprite/ALU result mux, branch-condition evaluation, and a
// direct-mapped write-through single-word-line data cache in front of a
// req/ack backing memory. Read misses and all writes stall the pipeline.
module mem_stage_cache #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              sprite_ALU_select,
  input  logic [DATA_W-1:0] sprite_data,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic              flag_ov,
  input  logic              flag_neg,
  input  logic              flag_zero,
  input  logic [2:0]        branch_condition,
  output logic [DATA_W-1:0] mem_result,
  output logic              cache_hit,
  output logic              stall,
  output logic [DATA_W-1:0] sprite_ALU_result,
  output logic              branch_taken,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];
  logic [DATA_W-1:0] fill;
  logic              was_read;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   atag;
  logic               hit;
  logic               rd_req;
  logic               stall_i, hit_i, req_i;
  logic [DATA_W-1:0]  result_i;

  assign idx    = addr[INDEX_W-1:0];
  assign atag   = addr[ADDR_W-1:INDEX_W];
  assign hit    = valid[idx] && (tag_arr[idx] == atag);
  assign rd_req = re && !we;

  assign sprite_ALU_result = sprite_ALU_select ? sprite_data : ALU_result;

  // Branch decision from the ALU flags
  always_comb begin
    branch_taken = 1'b0;
    case (branch_condition)
      3'b000: branch_taken = !flag_zero;
      3'b001: branch_taken = flag_zero;
      3'b010: branch_taken = !flag_zero && !flag_neg;
      3'b011: branch_taken = flag_neg;
      3'b100: branch_taken = !flag_neg;
      3'b101: branch_taken = flag_neg || flag_zero;
      3'b110: branch_taken = flag_ov;
      default: branch_taken = 1'b1;
    endcase
  end

  // Next-state and internal (pre-reset-gating) output decode
  always_comb begin
    state_nxt = state;
    stall_i   = 1'b0;
    hit_i     = 1'b0;
    req_i     = 1'b0;
    result_i  = '0;
    case (state)
      IDLE: begin
        if (we) begin
          stall_i   = 1'b1;
          state_nxt = WRITE;
        end else if (re) begin
          if (hit) begin
            hit_i    = 1'b1;
            result_i = data_arr[idx];
          end else begin
            stall_i   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      FETCH, WRITE: begin
        stall_i = 1'b1;
        req_i   = 1'b1;
        if (mem_ack) state_nxt = DONE;
      end
      default: begin
        result_i  = was_read ? fill : '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset forces the handshake and pipeline controls low asynchronously
  assign stall      = rst_n && stall_i;
  assign cache_hit  = rst_n && hit_i;
  assign mem_req    = rst_n && req_i;
  assign mem_we     = rst_n && req_i && (state == WRITE);
  assign mem_result = rst_n ? result_i : '0;
  assign mem_addr   = addr;
  assign mem_wdata  = wr_data;

  // FSM, valid bits, fill register and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      fill       <= '0;
      was_read   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && !we && re) begin
        if (hit) begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else if (miss_count != '1) begin
          miss_count <= miss_count + 1'b1;
        end
      end
      if (state == IDLE && (we || re)) was_read <= rd_req;
      if (state == FETCH && mem_ack) fill <= mem_rdata;
      // flush overrides a coincident fill: data returns but line stays invalid
      if (flush) valid <= '0;
      else if (state == FETCH && mem_ack) valid[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; only valid bits qualify them
  always_ff @(posedge clk) begin
    if (state == FETCH && mem_ack) begin
      tag_arr[idx]  <= atag;
      data_arr[idx] <= mem_rdata;
    end else if (state == WRITE && mem_ack && hit) begin
      data_arr[idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_cache.sv
// Directed bench for mem_stage_cache with hand-computed expectations.
module tb_mem_stage_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we, flush;
  logic [21:0] addr;
  logic [31:0] wr_data;
  logic        sprite_ALU_select;
  logic [31:0] sprite_data, ALU_result;
  logic        flag_ov, flag_neg, flag_zero;
  logic [2:0]  branch_condition;
  logic [31:0] mem_result;
  logic        cache_hit, stall;
  logic [31:0] sprite_ALU_result;
  logic        branch_taken;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_cache #(.ADDR_W(22), .DATA_W(32), .INDEX_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wr_data(wr_data),
    .flush(flush), .sprite_ALU_select(sprite_ALU_select), .sprite_data(sprite_data),
    .ALU_result(ALU_result), .flag_ov(flag_ov), .flag_neg(flag_neg),
    .flag_zero(flag_zero), .branch_condition(branch_condition),
    .mem_result(mem_result), .cache_hit(cache_hit), .stall(stall),
    .sprite_ALU_result(sprite_ALU_result), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One load/store: lat = number of mem_req cycles until ack (ack in that cycle)
  int          op_stall, op_req;
  logic        op_hit, op_sawwe;
  logic [31:0] op_res, op_wdata;

  task automatic run_op(input logic is_wr, input logic [21:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int lat, input logic fl_at_ack);
    logic done;
    done = 1'b0;
    op_stall = 0; op_req = 0; op_hit = 1'b0; op_sawwe = 1'b0;
    op_res = '0; op_wdata = '0;
    @(negedge clk);
    re = !is_wr; we = is_wr; addr = a; wr_data = wd;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (c == 0) op_hit = cache_hit;
      if (!stall) begin
        op_res = mem_result;
        done = 1'b1;
        break;
      end
      op_stall++;
      if (mem_req) begin
        op_req++;
        if (mem_we) op_sawwe = 1'b1;
        op_wdata = mem_wdata;
        if (op_req == lat) begin
          mem_ack = 1'b1; mem_rdata = rd; flush = fl_at_ack;
        end
      end
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0; flush = 1'b0;
    end
    if (!done) check("op_timeout", 32'd1, 32'd0);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic exp_bt;
    rst_n = 1'b0; re = 1'b1; we = 1'b0; flush = 1'b0; addr = 22'h5; wr_data = '0;
    sprite_ALU_select = 1'b0; sprite_data = 32'hA5A5A5A5; ALU_result = 32'h5A5A5A5A;
    flag_ov = 1'b0; flag_neg = 1'b0; flag_zero = 1'b0; branch_condition = 3'b000;
    mem_rdata = '0; mem_ack = 1'b0;
    #22;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hit", {31'd0, cache_hit}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_result", mem_result, 32'd0);
    check("rst_hitcnt", {16'd0, hit_count}, 32'd0);
    check("rst_misscnt", {16'd0, miss_count}, 32'd0);
    re = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, 3-cycle ack
    run_op(1'b0, 22'h5, '0, 32'hDEADBEEF, 3, 1'b0);
    check("miss1_hit", {31'd0, op_hit}, 32'd0);
    check("miss1_stall", op_stall, 32'd4);
    check("miss1_req", op_req, 32'd3);
    check("miss1_data", op_res, 32'hDEADBEEF);
    check("miss1_cnt", {16'd0, miss_count}, 32'd1);
    run_op(1'b0, 22'h5, '0, '0, 1, 1'b0);
    check("hit1_hit", {31'd0, op_hit}, 32'd1);
    check("hit1_stall", op_stall, 32'd0);
    check("hit1_data", op_res, 32'hDEADBEEF);
    check("hit1_cnt", {16'd0, hit_count}, 32'd1);

    // Conflict miss on the same index
    run_op(1'b0, 22'h5, '0, '0, 1, 1'b0);
    check("hit2_hit", {31'd0, op_hit}, 32'd1);
    run_op(1'b0, 22'h25, '0, 32'h00000025, 2, 1'b0);
    check("conf_hit", {31'd0, op_hit}, 32'd0);
    check("conf_data", op_res, 32'h00000025);
    run_op(1'b0, 22'h5, '0, 32'h11110005, 1, 1'b0);
    check("evict_hit", {31'd0, op_hit}, 32'd0);
    check("evict_data", op_res, 32'h11110005);
    check("conf_misscnt", {16'd0, miss_count}, 32'd3);
    check("conf_hitcnt", {16'd0, hit_count}, 32'd2);

    // Write-through to a cached line
    run_op(1'b1, 22'h5, 32'h12345678, '0, 2, 1'b0);
    check("wr_stall", op_stall, 32'd3);
    check("wr_we", {31'd0, op_sawwe}, 32'd1);
    check("wr_wdata", op_wdata, 32'h12345678);
    check("wr_done_res", op_res, 32'd0);
    run_op(1'b0, 22'h5, '0, '0, 1, 1'b0);
    check("wr_rd_hit", {31'd0, op_hit}, 32'd1);
    check("wr_rd_data", op_res, 32'h12345678);
    // No write-allocate
    run_op(1'b1, 22'h100, 32'h0BADF00D, '0, 1, 1'b0);
    run_op(1'b0, 22'h100, '0, 32'h0000CAFE, 1, 1'b0);
    check("nowa_hit", {31'd0, op_hit}, 32'd0);
    check("nowa_data", op_res, 32'h0000CAFE);

    // Flush coinciding with the fill ack
    run_op(1'b0, 22'h7, '0, 32'h77777777, 2, 1'b1);
    check("flack_data", op_res, 32'h77777777);
    run_op(1'b0, 22'h7, '0, 32'h77777777, 1, 1'b0);
    check("flack_miss", {31'd0, op_hit}, 32'd0);
    run_op(1'b0, 22'h7, '0, '0, 1, 1'b0);
    check("refill_hit", {31'd0, op_hit}, 32'd1);
    // Flush in IDLE
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    run_op(1'b0, 22'h7, '0, 32'h77777777, 1, 1'b0);
    check("flidle_miss7", {31'd0, op_hit}, 32'd0);
    run_op(1'b0, 22'h5, '0, 32'h12345678, 1, 1'b0);
    check("flidle_miss5", {31'd0, op_hit}, 32'd0);
    check("pre_rst_misscnt", {16'd0, miss_count}, 32'd8);
    check("pre_rst_hitcnt", {16'd0, hit_count}, 32'd4);

    // Reset mid-FETCH
    @(negedge clk); re = 1'b1; addr = 22'h9;
    @(negedge clk); #1;
    check("fetch_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0; #1;
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_hitcnt", {16'd0, hit_count}, 32'd0);
    check("abort_misscnt", {16'd0, miss_count}, 32'd0);
    @(negedge clk); re = 1'b0; rst_n = 1'b1;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); mem_ack = 1'b0;
    run_op(1'b0, 22'h5, '0, 32'h55555555, 1, 1'b0);
    check("post_rst_miss", {31'd0, op_hit}, 32'd0);
    check("post_rst_data", op_res, 32'h55555555);

    // Hit counter saturation: hold a hitting read in IDLE
    @(negedge clk); re = 1'b1; addr = 22'h5;
    repeat (65534) @(negedge clk);
    check("hitcnt_fffe", {16'd0, hit_count}, 32'h0000FFFE);
    repeat (6) @(negedge clk);
    check("hitcnt_sat", {16'd0, hit_count}, 32'h0000FFFF);
    check("misscnt_after", {16'd0, miss_count}, 32'd1);
    re = 1'b0;

    // Branch table and result mux
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [2:0] fl;
        fl = f[2:0];
        branch_condition = c[2:0];
        {flag_ov, flag_neg, flag_zero} = fl;
        case (c)
          0: exp_bt = !fl[0];
          1: exp_bt = fl[0];
          2: exp_bt = !fl[0] && !fl[1];
          3: exp_bt = fl[1];
          4: exp_bt = !fl[1];
          5: exp_bt = fl[1] || fl[0];
          6: exp_bt = fl[2];
          default: exp_bt = 1'b1;
        endcase
        #1;
        check("branch", {24'd0, c[2:0], f[2:0], 1'b0, branch_taken}, {24'd0, c[2:0], f[2:0], 1'b0, exp_bt});
      end
    end
    sprite_ALU_select = 1'b1; #1;
    check("mux_sprite", sprite_ALU_result, 32'hA5A5A5A5);
    sprite_ALU_select = 1'b0; #1;
    check("mux_alu", sprite_ALU_result, 32'h5A5A5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
